mbinit_repairval_module: RTL

- Requester-side state machine for the MBINIT.REPAIRVAL step of link training.
- Sits directly downstream of the REPAIRCLK stage and starts when i_MBINIT_REPAIRCLK_end rises.
- Sequence: exchanges init/result/done sideband messages with the partner; drives the valid-lane training pattern for a counted duration; checks the logged valid-lane result.
- Signals completion to the REVERSALMB stage, or raises a training error.

---
 rtl/mbinit_repairval_module_if.sv | 46 ++++
 rtl/mbinit_repairval_module.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mbinit_repairval_module_if.sv
// Sideband/handshake bundle between the MBINIT.REPAIRVAL requester and its surroundings.
// master: the environment (sideband, partner, REPAIRCLK stage); slave: the requester FSM.
interface mbinit_repairval_module_if;
   logic       i_MBINIT_REPAIRCLK_end;
   logic [3:0] i_Rx_SbMessage;
   logic       i_msg_valid;
   logic       i_Busy_SideBand;
   logic       i_falling_edge_busy;
   logic       i_ValidOutDatat_ModulePartner;
   logic       i_VAL_result_logged;
   logic       o_train_error_req;
   logic       o_MBINIT_REPAIRVAL_Pattern_En;
   logic       o_MBINIT_REPAIRVAL_Module_end;
   logic [3:0] o_TX_SbMessage;
   logic       o_ValidOutDatat_Module;

   modport master (
      output i_MBINIT_REPAIRCLK_end,
      output i_Rx_SbMessage,
      output i_msg_valid,
      output i_Busy_SideBand,
      output i_falling_edge_busy,
      output i_ValidOutDatat_ModulePartner,
      output i_VAL_result_logged,
      input  o_train_error_req,
      input  o_MBINIT_REPAIRVAL_Pattern_En,
      input  o_MBINIT_REPAIRVAL_Module_end,
      input  o_TX_SbMessage,
      input  o_ValidOutDatat_Module
   );

   modport slave (
      input  i_MBINIT_REPAIRCLK_end,
      input  i_Rx_SbMessage,
      input  i_msg_valid,
      input  i_Busy_SideBand,
      input  i_falling_edge_busy,
      input  i_ValidOutDatat_ModulePartner,
      input  i_VAL_result_logged,
      output o_train_error_req,
      output o_MBINIT_REPAIRVAL_Pattern_En,
      output o_MBINIT_REPAIRVAL_Module_end,
      output o_TX_SbMessage,
      output o_ValidOutDatat_Module
   );
endinterface

// File: rtl/mbinit_repairval_module.sv
// Requester FSM for MBINIT.REPAIRVAL: init/pattern/result/done exchange with the link partner.
// Optional wait-state timeout is enabled by defining MBINIT_REPAIRVAL_TIMEOUT_EN.
module mbinit_repairval_module #(
   parameter int unsigned PATTERN_CYCLES = 128,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   mbinit_repairval_module_if.slave sb
);
   localparam int unsigned MSG_W  = 4;
   localparam int unsigned PCNT_W = $clog2(PATTERN_CYCLES) + 1;

   localparam logic [MSG_W-1:0] MSG_NONE        = 4'b0000;
   localparam logic [MSG_W-1:0] MSG_INIT_REQ    = 4'b0001;
   localparam logic [MSG_W-1:0] MSG_INIT_RESP   = 4'b0010;
   localparam logic [MSG_W-1:0] MSG_RESULT_REQ  = 4'b0011;
   localparam logic [MSG_W-1:0] MSG_RESULT_RESP = 4'b0100;
   localparam logic [MSG_W-1:0] MSG_DONE_REQ    = 4'b0101;
   localparam logic [MSG_W-1:0] MSG_DONE_RESP   = 4'b0110;

   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PATTERN_CYCLES - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT_REQ,
      ST_WAIT_RESP,
      ST_PATTERN,
      ST_CHECK_BUSY_RESULT,
      ST_RESULT_REQ,
      ST_CHECK_RESULT,
      ST_CHECK_BUSY_DONE,
      ST_DONE_REQ,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic                result_q, result_d;

   logic                train_error_q;
   logic                pattern_en_q;
   logic                module_end_q;
   logic [MSG_W-1:0]    tx_msg_q;
   logic                tx_valid_q;

   logic                en_c;
   logic                fe_c;
   logic                partner_c;
   logic                sb_free_c;
   logic                rx_valid_c;
   logic [MSG_W-1:0]    rx_msg_c;

   assign en_c       = sb.i_MBINIT_REPAIRCLK_end;
   assign fe_c       = sb.i_falling_edge_busy;
   assign partner_c  = sb.i_ValidOutDatat_ModulePartner;
   assign sb_free_c  = ~sb.i_Busy_SideBand & ~sb.i_ValidOutDatat_ModulePartner;
   assign rx_valid_c = sb.i_msg_valid;
   assign rx_msg_c   = sb.i_Rx_SbMessage;

`ifdef MBINIT_REPAIRVAL_TIMEOUT_EN
   localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic                timed_c;

   // Every state that waits on the partner or the sideband is guarded by the timer.
   assign timed_c = state_q inside {ST_INIT_REQ, ST_WAIT_RESP, ST_CHECK_BUSY_RESULT,
                                    ST_RESULT_REQ, ST_CHECK_BUSY_DONE, ST_DONE_REQ};
`else
   logic                unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

   // Message carried by each request state; all other states transmit nothing.
   function automatic logic [MSG_W-1:0] req_msg(input state_t s);
      case (s)
         ST_INIT_REQ:   req_msg = MSG_INIT_REQ;
         ST_RESULT_REQ: req_msg = MSG_RESULT_REQ;
         ST_DONE_REQ:   req_msg = MSG_DONE_REQ;
         default:       req_msg = MSG_NONE;
      endcase
   endfunction

   // Next-state and counter logic; enable loss overrides everything.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      pcnt_d   = '0;
`ifdef MBINIT_REPAIRVAL_TIMEOUT_EN
      tcnt_d   = '0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (en_c && !sb.i_Busy_SideBand) state_d = ST_INIT_REQ;
         end
         ST_INIT_REQ: begin
            if (fe_c) state_d = ST_WAIT_RESP;
         end
         ST_WAIT_RESP: begin
            if (rx_valid_c) begin
               if (rx_msg_c == MSG_INIT_RESP) begin
                  state_d = ST_PATTERN;
               end else if (rx_msg_c == MSG_RESULT_RESP) begin
                  state_d  = ST_CHECK_RESULT;
                  result_d = sb.i_VAL_result_logged;
               end else if (rx_msg_c == MSG_DONE_RESP) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_PATTERN: begin
            if (pcnt_q == PCNT_LAST) state_d = ST_CHECK_BUSY_RESULT;
         end
         ST_CHECK_BUSY_RESULT: begin
            if (sb_free_c) state_d = ST_RESULT_REQ;
         end
         ST_RESULT_REQ: begin
            if (fe_c && !partner_c) state_d = ST_WAIT_RESP;
         end
         ST_CHECK_RESULT: begin
            state_d = result_q ? ST_CHECK_BUSY_DONE : ST_ERROR;
         end
         ST_CHECK_BUSY_DONE: begin
            if (sb_free_c) state_d = ST_DONE_REQ;
         end
         ST_DONE_REQ: begin
            if (fe_c && !partner_c) state_d = ST_WAIT_RESP;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef MBINIT_REPAIRVAL_TIMEOUT_EN
      if (timed_c && (state_d == state_q) && (tcnt_q == TCNT_LAST)) state_d = ST_ERROR;
`endif

      if ((state_q != ST_IDLE) && !en_c) begin
         state_d  = ST_IDLE;
         result_d = 1'b0;
      end

      // Counters only advance while the state holds, so any exit clears them.
      if ((state_q == ST_PATTERN) && (state_d == ST_PATTERN)) pcnt_d = pcnt_q + PCNT_W'(1);
`ifdef MBINIT_REPAIRVAL_TIMEOUT_EN
      if (timed_c && (state_d == state_q)) tcnt_d = tcnt_q + TCNT_W'(1);
`endif
   end

   // State register with outputs decoded from the next state.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pcnt_q        <= '0;
         result_q      <= 1'b0;
         train_error_q <= 1'b0;
         pattern_en_q  <= 1'b0;
         module_end_q  <= 1'b0;
         tx_msg_q      <= MSG_NONE;
         tx_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pcnt_q        <= pcnt_d;
         result_q      <= result_d;
         train_error_q <= (state_d == ST_ERROR);
         pattern_en_q  <= (state_d == ST_PATTERN);
         module_end_q  <= (state_d == ST_DONE);
         tx_msg_q      <= req_msg(state_d);
         tx_valid_q    <= (state_d == ST_INIT_REQ) || (state_d == ST_RESULT_REQ) ||
                          (state_d == ST_DONE_REQ);
      end
   end

`ifdef MBINIT_REPAIRVAL_TIMEOUT_EN
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) tcnt_q <= '0;
      else        tcnt_q <= tcnt_d;
   end
`endif

   assign sb.o_train_error_req             = train_error_q;
   assign sb.o_MBINIT_REPAIRVAL_Pattern_En = pattern_en_q;
   assign sb.o_MBINIT_REPAIRVAL_Module_end = module_end_q;
   assign sb.o_TX_SbMessage                = tx_msg_q;
   assign sb.o_ValidOutDatat_Module        = tx_valid_q;

endmodule
